// File: rtl/adder_bist_checker.sv
// Built-in self-test checker for a 16-bit adder: drives LFSR operands, checks {cout,sum}.
// Optional corner-vector prologue enabled by defining ADDER_BIST_CORNERS_EN.
module adder_bist_checker #(
  parameter int          NUM_VECTORS = 256,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [15:0] dut_a,
  output logic [15:0] dut_b,
  output logic        dut_cin,
  input  logic [15:0] dut_sum,
  input  logic        dut_cout,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_count,
  output logic [15:0] first_fail_idx
);

`ifdef ADDER_BIST_CORNERS_EN
  localparam int NUM_CORNERS = 4;
`else
  localparam int NUM_CORNERS = 0;
`endif
  localparam logic [16:0] LAST_IDX = 17'(NUM_VECTORS + NUM_CORNERS - 1);

  typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_t;

  state_t      state_q;
  logic [16:0] idx_q;
  logic [15:0] lfsr_q;
  logic [15:0] dut_a_q, dut_b_q;
  logic        dut_cin_q;
  logic        busy_q, done_q, pass_q;
  logic [15:0] err_count_q, first_fail_idx_q;

  logic [16:0] idx_d;
  logic [15:0] lfsr_d;
  logic [32:0] vec_d;
  logic [32:0] first_vec;
  logic [16:0] exp_sum;
  logic        mismatch;
  logic [15:0] err_count_d;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // Packed as {a, b, cin}
  function automatic logic [32:0] rand_vec(input logic [15:0] l, input logic c);
    return {l, l[7:0], l[15:8], c};
  endfunction

`ifdef ADDER_BIST_CORNERS_EN
  function automatic logic [32:0] corner_vec(input logic [1:0] k);
    logic [32:0] v;
    case (k)
      2'd0:    v = {16'h0000, 16'h0000, 1'b0};
      2'd1:    v = {16'hFFFF, 16'h0001, 1'b0};
      2'd2:    v = {16'hFFFF, 16'hFFFF, 1'b1};
      default: v = {16'h5555, 16'hAAAA, 1'b1};
    endcase
    return v;
  endfunction
`endif

  always_comb begin
    idx_d = idx_q + 17'd1;
`ifdef ADDER_BIST_CORNERS_EN
    // LFSR stays at SEED until the first random vector has been consumed
    lfsr_d    = (idx_q >= 17'd4) ? lfsr_step(lfsr_q) : lfsr_q;
    vec_d     = (idx_d < 17'd4) ? corner_vec(idx_d[1:0]) : rand_vec(lfsr_d, idx_d[0]);
    first_vec = corner_vec(2'd0);
`else
    lfsr_d    = lfsr_step(lfsr_q);
    vec_d     = rand_vec(lfsr_d, idx_d[0]);
    first_vec = rand_vec(SEED, 1'b0);
`endif
    exp_sum     = {1'b0, dut_a_q} + {1'b0, dut_b_q} + {16'd0, dut_cin_q};
    mismatch    = ({dut_cout, dut_sum} != exp_sum);
    err_count_d = (mismatch && err_count_q != 16'hFFFF) ? err_count_q + 16'd1 : err_count_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      idx_q            <= '0;
      lfsr_q           <= SEED;
      dut_a_q          <= '0;
      dut_b_q          <= '0;
      dut_cin_q        <= 1'b0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      pass_q           <= 1'b0;
      err_count_q      <= '0;
      first_fail_idx_q <= 16'hFFFF;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q                         <= APPLY;
            idx_q                           <= '0;
            lfsr_q                          <= SEED;
            {dut_a_q, dut_b_q, dut_cin_q}   <= first_vec;
            busy_q                          <= 1'b1;
            done_q                          <= 1'b0;
            pass_q                          <= 1'b0;
            err_count_q                     <= '0;
            first_fail_idx_q                <= 16'hFFFF;
          end
        end
        APPLY: state_q <= CHECK;
        CHECK: begin
          err_count_q <= err_count_d;
          if (mismatch && first_fail_idx_q == 16'hFFFF)
            first_fail_idx_q <= idx_q[15:0];
          if (idx_q == LAST_IDX) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_count_d == 16'd0);
          end else begin
            state_q                       <= APPLY;
            idx_q                         <= idx_d;
            lfsr_q                        <= lfsr_d;
            {dut_a_q, dut_b_q, dut_cin_q} <= vec_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dut_a          = dut_a_q;
  assign dut_b          = dut_b_q;
  assign dut_cin        = dut_cin_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_count_q;
  assign first_fail_idx = first_fail_idx_q;

endmodule

// File: tb/tb_adder_bist_checker.sv
// Scoreboard bench for adder_bist_checker: healthy and faulty adder models, restart and reset abort.
module tb_adder_bist_checker;

`ifdef ADDER_BIST_CORNERS_EN
  localparam int NC = 4;
  localparam logic [15:0] V0_A = 16'h0000, V0_B = 16'h0000; localparam logic V0_C = 1'b0;
  localparam logic [15:0] V1_A = 16'hFFFF, V1_B = 16'h0001; localparam logic V1_C = 1'b0;
  localparam logic [15:0] FFI_SUM0 = 16'd2, FFI_COUT = 16'd1;
`else
  localparam int NC = 0;
  localparam logic [15:0] V0_A = 16'hACE1, V0_B = 16'hE1AC; localparam logic V0_C = 1'b0;
  localparam logic [15:0] V1_A = 16'h59C3, V1_B = 16'hC359; localparam logic V1_C = 1'b1;
  localparam logic [15:0] FFI_SUM0 = 16'd0, FFI_COUT = 16'd0;
`endif
  localparam int NV = 256;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [15:0] dut_a, dut_b, dut_sum, err_count, first_fail_idx;
  logic dut_cin, dut_cout, busy, done, pass;
  int fault_mode = 0;

  always #5 clk = ~clk;

  adder_bist_checker #(.NUM_VECTORS(NV), .SEED(16'hACE1)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .dut_a(dut_a), .dut_b(dut_b), .dut_cin(dut_cin),
    .dut_sum(dut_sum), .dut_cout(dut_cout),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_fail_idx(first_fail_idx)
  );

  // Adder under test with selectable faults: 1 = sum[0] stuck at 0, 2 = cout dropped
  logic [16:0] true_sum;
  assign true_sum = {1'b0, dut_a} + {1'b0, dut_b} + {16'd0, dut_cin};
  always_comb begin
    {dut_cout, dut_sum} = true_sum;
    if (fault_mode == 1) dut_sum[0] = 1'b0;
    else if (fault_mode == 2) dut_cout = 1'b0;
  end

  typedef struct packed {
    logic [31:0] len;
    logic        pass;
    logic [15:0] err;
    logic [15:0] ffi;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference count of mismatching vectors for a given fault mode
  function automatic logic [15:0] model_errs(input int mode);
    logic [15:0] ca [4];
    logic [15:0] cb [4];
    logic        cc [4];
    logic [15:0] l, a, b, e;
    logic        c;
    logic [16:0] t, g;
    ca = '{16'h0000, 16'hFFFF, 16'hFFFF, 16'h5555};
    cb = '{16'h0000, 16'h0001, 16'hFFFF, 16'hAAAA};
    cc = '{1'b0, 1'b0, 1'b1, 1'b1};
    l = 16'hACE1;
    e = '0;
    for (int i = 0; i < NC + NV; i++) begin
      if (i < NC) begin
        a = ca[i]; b = cb[i]; c = cc[i];
      end else begin
        a = l; b = {l[7:0], l[15:8]}; c = i[0];
        l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
      end
      t = {1'b0, a} + {1'b0, b} + {16'd0, c};
      g = t;
      if (mode == 1) g[0] = 1'b0;
      if (mode == 2) g[16] = 1'b0;
      if (g != t && e != 16'hFFFF) e = e + 16'd1;
    end
    return e;
  endfunction

  task automatic expect_run(input int mode);
    exp_t x;
    x.len  = 32'(2 * (NV + NC));
    x.err  = model_errs(mode);
    x.pass = (x.err == 16'd0);
    x.ffi  = (mode == 1) ? FFI_SUM0 : (mode == 2) ? FFI_COUT : 16'hFFFF;
    sb.push_back(x);
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
  endtask

  task automatic wait_done();
    int k = 0;
    while (!done && k < 4000) begin
      @(posedge clk); #1; k++;
    end
    chk("done_timeout", {31'd0, done}, 32'd1);
  endtask

  // Monitor: measures busy length and pops the scoreboard on each rising done
  int   run_len = 0;
  logic busy_prev = 1'b0, done_prev = 1'b0;
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (busy) run_len = busy_prev ? run_len + 1 : 1;
      if (done && !done_prev) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("run_len", 32'(run_len), e.len);
          chk("pass", {31'd0, pass}, {31'd0, e.pass});
          chk("err_count", {16'd0, err_count}, {16'd0, e.err});
          chk("first_fail_idx", {16'd0, first_fail_idx}, {16'd0, e.ffi});
          $display("run done len=%0d pass=%0b err=%0d ffi=%0h", run_len, pass, err_count, first_fail_idx);
        end
      end
      busy_prev = busy;
      done_prev = done;
    end
  end

  initial begin
    // Reset with start held: start must be ignored
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_pass", {31'd0, pass}, 32'd0);
    chk("rst_err", {16'd0, err_count}, 32'd0);
    chk("rst_ffi", {16'd0, first_fail_idx}, 32'hFFFF);
    chk("rst_a", {16'd0, dut_a}, 32'd0);
    chk("rst_b", {16'd0, dut_b}, 32'd0);
    chk("rst_cin", {31'd0, dut_cin}, 32'd0);
    @(negedge clk); start = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // Healthy adder run with first-vector checks
    fault_mode = 0;
    expect_run(0);
    pulse_start();
    chk("v0_a", {16'd0, dut_a}, {16'd0, V0_A});
    chk("v0_b", {16'd0, dut_b}, {16'd0, V0_B});
    chk("v0_cin", {31'd0, dut_cin}, {31'd0, V0_C});
    chk("busy_run", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    chk("v0_a_stable", {16'd0, dut_a}, {16'd0, V0_A});
    chk("v0_sum", {15'd0, dut_cout, dut_sum}, (V0_A == 16'hACE1) ? 32'h18E8D : 32'h0);
    @(posedge clk); #1;
    chk("v1_a", {16'd0, dut_a}, {16'd0, V1_A});
    chk("v1_b", {16'd0, dut_b}, {16'd0, V1_B});
    chk("v1_cin", {31'd0, dut_cin}, {31'd0, V1_C});
    wait_done();

    // sum[0] stuck at 0, then results must hold in DONE
    fault_mode = 1;
    expect_run(1);
    pulse_start();
    wait_done();
    repeat (5) @(posedge clk);
    #1;
    chk("hold_done", {31'd0, done}, 32'd1);
    chk("hold_pass", {31'd0, pass}, 32'd0);
    chk("hold_ffi", {16'd0, first_fail_idx}, {16'd0, FFI_SUM0});

    // Restart from DONE with a start pulse ignored mid-run
    fault_mode = 0;
    expect_run(0);
    pulse_start();
    chk("restart_err_clr", {16'd0, err_count}, 32'd0);
    chk("restart_ffi_clr", {16'd0, first_fail_idx}, 32'hFFFF);
    repeat (48) @(posedge clk);
    pulse_start();
    wait_done();

    // Dropped carry-out
    fault_mode = 2;
    expect_run(2);
    pulse_start();
    wait_done();

    // Reset in the middle of a faulty run aborts it
    fault_mode = 1;
    pulse_start();
    repeat (99) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_err", {16'd0, err_count}, 32'd0);
    chk("abort_ffi", {16'd0, first_fail_idx}, 32'hFFFF);
    @(negedge clk); rst_n = 1'b1;
    fault_mode = 0;
    expect_run(0);
    pulse_start();
    chk("after_abort_a", {16'd0, dut_a}, {16'd0, V0_A});
    wait_done();

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adder_bist_checker.md
ADDER_BIST_CHECKER -- requirements
Module: adder_bist_checker

Interface
REQ-001 Parameter NUM_VECTORS, default 256, meaning number of pseudo-random vectors per run (range 1..65535).
REQ-002 Parameter SEED, default 16'hACE1, meaning LFSR start value (nonzero).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  one-cycle request to begin a test run.
REQ-006 dut_a, dut_b  output  16 each  stimulus operands to the adder under test.
REQ-007 dut_cin  output  1  stimulus carry-in.
REQ-008 dut_sum  input  16  adder under test sum, combinational response to dut_a/dut_b/dut_cin.
REQ-009 dut_cout  input  1  adder under test carry-out.
REQ-010 busy  output  1  high while a run is in progress.
REQ-011 done  output  1  high once a run has finished, held until the next accepted start.
REQ-012 pass  output  1  valid while done; high iff err_count == 0.
REQ-013 err_count  output  16  mismatching vectors in the current/last run, saturating.
REQ-014 first_fail_idx  output  16  index of first mismatching vector; 16'hFFFF if none.

Function
REQ-015 FSM states IDLE, APPLY, CHECK, DONE; exactly one active.
REQ-016 IDLE: start=1 -> APPLY; clear err_count, set first_fail_idx=16'hFFFF, idx=0, lfsr=SEED (or corner index 0 under REQ-031).
REQ-017 APPLY (1 cycle): dut_a=lfsr, dut_b={lfsr[7:0],lfsr[15:8]}, dut_cin=idx[0], all registered; -> CHECK.
REQ-018 dut_a/dut_b/dut_cin SHALL stay stable through APPLY and CHECK of one vector.
REQ-019 CHECK (1 cycle): at the edge ending CHECK compare {dut_cout,dut_sum} with 17-bit expected dut_a+dut_b+dut_cin.
REQ-020 Mismatch: err_count increments, saturating at 16'hFFFF; first_fail_idx captures idx only if still 16'hFFFF.
REQ-021 CHECK end: idx==NUM_VECTORS-1 -> DONE, else idx+1, lfsr advances, -> APPLY.
REQ-022 LFSR step: next = {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}.
REQ-023 Run length exactly 2*NUM_VECTORS cycles APPLY+CHECK; done rises the cycle after the last CHECK.
REQ-024 busy=1 in APPLY and CHECK only; done=1 in DONE only; pass=(err_count==0) in DONE, 0 elsewhere.
REQ-025 start while busy SHALL be ignored; start in DONE restarts exactly as from IDLE.
REQ-026 err_count and first_fail_idx hold their values in DONE and IDLE until the next accepted start.

Reset
REQ-027 rst_n=0 at a rising edge: state=IDLE, idx=0, lfsr=SEED, dut_a=0, dut_b=0, dut_cin=0, busy=0, done=0, pass=0, err_count=0, first_fail_idx=16'hFFFF.
REQ-028 Reset mid-run aborts immediately, no partial result retained; start in the same cycle as rst_n=0 is ignored.
REQ-029 No output changes without a clock edge.

Configuration
REQ-030 Macro ADDER_BIST_CORNERS_EN selects the corner-vector prologue.
REQ-031 Defined: 4 corner vectors (a,b,cin) = (0000,0000,0), (FFFF,0001,0), (FFFF,FFFF,1), (5555,AAAA,1) precede the NUM_VECTORS random vectors, indices 0..3, random indices shift by 4, run = 2*(NUM_VECTORS+4) cycles; lfsr held at SEED during corners.
REQ-032 Undefined: no corner vectors; random vectors only, behaviour per REQ-016..REQ-023.

Verification
REQ-033 Correct adder, NUM_VECTORS=256, macro off: start -> done after 512 cycles, pass=1, err_count=0, first_fail_idx=FFFF.
REQ-034 First vector, macro off: APPLY shows dut_a=ACE1, dut_b=E1AC, dut_cin=0; expected {cout,sum}=1_8E8D.
REQ-035 Adder with sum[0] stuck at 0: err_count>0, first_fail_idx = lowest index whose true sum[0]=1, pass=0.
REQ-036 rst_n=0 at cycle 100 of a run: next cycle busy=0, done=0, err_count=0; new start gives identical run as from reset.
REQ-037 start pulsed during busy at cycle 50: run length unchanged; start pulse in DONE restarts and clears err_count.
REQ-038 Macro on, adder dropping cout: vector index 1 (FFFF+0001) fails first, first_fail_idx=1, done after 2*(256+4) cycles.
